// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit_pkg                                               |
// | Description : Shared constants for the instruction-fetch front end.        |
// |               Holds the fetch FSM state encodings. The DS_FETCH state is   |
// |               only used when TORU_DELAY_SLOT_EN is defined.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

    // Fetch FSM state encodings (explicit 1-bit width)
    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_DS_FETCH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit_queue                                             |
// | Description : DEPTH-entry synchronous prefetch FIFO of {pc, inst} pairs.   |
// |               Supports simultaneous push/pop, a full flush (optionally     |
// |               combined with a push into the emptied queue) and a           |
// |               keep_second operation that leaves only entry head+1.         |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               push/push_pc/push_inst - write {pc,inst} at tail             |
// |               pop               - retire head entry                        |
// |               flush             - empty the queue (push still honoured)    |
// |               keep_second       - keep only entry head+1                   |
// |               head_valid/head_pc/head_inst - head entry, zero when empty   |
// |               count             - number of valid entries                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [DATA_W-1:0]        push_inst,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     keep_second,
    output logic                     head_valid,
    output logic [ADDR_W-1:0]        head_pc,
    output logic [DATA_W-1:0]        head_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_idx;

    // A push that coincides with a flush lands in slot 0 of the emptied queue
    assign w_wr_idx = flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem_pc[w_wr_idx]   <= push_pc;
            r_mem_inst[w_wr_idx] <= push_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push ? PTR_W'(1) : '0;
            r_count  <= push ? CNT_W'(1) : '0;
        end else if (keep_second) begin
            // Storage is untouched; only the window moves to cover head+1 alone
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_wr_ptr <= r_rd_ptr + PTR_W'(2);
            r_count  <= CNT_W'(1);
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_valid = (r_count != '0);
    assign head_pc    = head_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign head_inst  = head_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction-fetch front end. Owns the PC, issues one         |
// |               synchronous-ROM read per cycle while the prefetch queue has  |
// |               room, buffers returned words and presents {pc,inst} to ID    |
// |               with a stall handshake. ID branch redirects flush the queue. |
// |               Build option TORU_DELAY_SLOT_EN: redirects keep the          |
// |               instruction after the branch (delay slot).                   |
// | Ports       : clk, rst (async, active-high)                                |
// |               rom_data_i  - ROM data, valid the cycle after rom_ce_o       |
// |               rom_ce_o    - ROM read strobe                                |
// |               rom_addr_o  - ROM read address (fetch PC)                    |
// |               stall_i     - ID cannot accept the head                      |
// |               branch_flag_i/branch_target_i - redirect, qualified by pop   |
// |               id_valid_o/id_pc_o/id_inst_o  - head entry, zero when empty  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;
    logic              r_inflight;
    logic              r_ce_en;

    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occupancy;
    logic              w_pop;
    logic              w_redirect;
    logic              w_issue;
    logic              w_q_push;
    logic              w_q_flush;
    logic              w_q_keep;
    logic [ADDR_W-1:0] w_pc_nxt;

`ifdef TORU_DELAY_SLOT_EN
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] w_target_nxt;
`endif

    // Queued entries plus the outstanding read must fit, so a full queue never sees a push
    assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight);
    assign w_pop       = id_valid_o & ~stall_i;
    assign w_redirect  = branch_flag_i & w_pop;
    assign w_issue     = r_ce_en & (w_occupancy < OCC_W'(DEPTH)) & ~w_redirect;

    assign rom_ce_o    = w_issue;
    assign rom_addr_o  = r_pc;

    always_comb begin
        w_q_push  = r_inflight;
        w_q_flush = 1'b0;
        w_q_keep  = 1'b0;
        w_pc_nxt  = w_issue ? (r_pc + ADDR_W'(PC_STEP)) : r_pc;
`ifdef TORU_DELAY_SLOT_EN
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        if (w_redirect) begin
            if (w_count >= CNT_W'(2)) begin
                // Delay slot already queued behind the branch
                w_q_keep = 1'b1;
                w_q_push = 1'b0;
                w_pc_nxt = branch_target_i;
            end else if (r_inflight) begin
                // Delay slot is the response arriving now; it refills the emptied queue
                w_q_flush = 1'b1;
                w_pc_nxt  = branch_target_i;
            end else begin
                // Delay slot not yet fetched: fetch it from the current pc first
                w_q_flush    = 1'b1;
                w_target_nxt = branch_target_i;
                w_state_nxt  = c_ST_DS_FETCH;
            end
        end else if ((r_state == c_ST_DS_FETCH) && w_issue) begin
            w_pc_nxt    = r_target;
            w_state_nxt = c_ST_RUN;
        end
`else
        if (w_redirect) begin
            w_q_flush = 1'b1;
            w_q_push  = 1'b0;
            w_pc_nxt  = branch_target_i;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_ce_en    <= 1'b0;
        end else begin
            r_ce_en    <= 1'b1;
            r_pc       <= w_pc_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_pc;
            end
        end
    end

`ifdef TORU_DELAY_SLOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_RUN;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end
`endif

    fetch_unit_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push        (w_q_push),
        .push_pc     (r_tag),
        .push_inst   (rom_data_i),
        .pop         (w_pop),
        .flush       (w_q_flush),
        .keep_second (w_q_keep),
        .head_valid  (id_valid_o),
        .head_pc     (id_pc_o),
        .head_inst   (id_inst_o),
        .count       (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit. The ROM model returns    |
// |               addr>>2, so every head instruction must equal head pc>>2.    |
// |               Delay-slot sequences are compiled when TORU_DELAY_SLOT_EN    |
// |               is defined.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rom_data;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_data_i      (rom_data),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .stall_i         (stall),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .id_valid_o      (id_valid),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the strobed address appears the following cycle
    initial rom_data = 32'h0;
    always @(posedge clk) begin
        if (rom_ce) rom_data <= rom_addr >> 2;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the first clock edge with ce_en set (cycle 0)
    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ce",    rom_ce,   32'h0);
        check("rst_addr",  rom_addr, 32'h0);
        check("rst_valid", id_valid, 32'h0);
        check("rst_pc",    id_pc,    32'h0);
        check("rst_inst",  id_inst,  32'h0);
        rst = 1'b0;
        step();
    endtask

    // Waits (bounded) for the next valid head with stall low and checks it
    task automatic next_pop(input string name, input logic [31:0] exp_pc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (id_valid) begin
                got = 1'b1;
                check(name, id_pc, exp_pc);
                check({name, "_inst"}, id_inst, exp_pc >> 2);
            end
            step();
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s no valid head within 20 cycles (expected pc=%h)", name, exp_pc);
        end
    endtask

    function automatic void add(input logic s, input logic b, input logic [31:0] t,
                                input logic ce, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t;
        x.exp_ce = ce; x.exp_addr = a; x.exp_valid = v; x.exp_pc = p;
        vecs.push_back(x);
    endfunction

    initial begin
        int          n;
        int          off;
        logic [31:0] issued[$];
        logic [31:0] ids[$];
        logic [31:0] exp_wrap[3];

        // ---------------- cycle table: stream, stall fill, drain, redirect ----------
        //   stall br tgt        ce addr      valid pc
        add(0, 0, 32'h0,   1, 32'h00,  0, 32'h00);
        add(0, 0, 32'h0,   1, 32'h04,  0, 32'h00);
        add(0, 0, 32'h0,   1, 32'h08,  1, 32'h00);
        add(0, 0, 32'h0,   1, 32'h0C,  1, 32'h04);
        add(0, 0, 32'h0,   1, 32'h10,  1, 32'h08);
        add(0, 0, 32'h0,   1, 32'h14,  1, 32'h0C);
        add(1, 0, 32'h0,   1, 32'h18,  1, 32'h10);
        add(1, 0, 32'h0,   1, 32'h1C,  1, 32'h10);
        add(1, 0, 32'h0,   0, 32'h20,  1, 32'h10);
        add(1, 1, 32'h300, 0, 32'h20,  1, 32'h10);  // branch while stalled: ignored
        add(1, 0, 32'h0,   0, 32'h20,  1, 32'h10);
        add(0, 0, 32'h0,   0, 32'h20,  1, 32'h10);  // pop from full queue, no issue yet
        add(0, 0, 32'h0,   1, 32'h20,  1, 32'h14);
        add(0, 0, 32'h0,   1, 32'h24,  1, 32'h18);
        add(0, 0, 32'h0,   1, 32'h28,  1, 32'h1C);
        add(0, 1, 32'h100, 0, 32'h2C,  1, 32'h20);  // redirect: no issue this cycle
`ifdef TORU_DELAY_SLOT_EN
        add(0, 0, 32'h0,   1, 32'h100, 1, 32'h24);  // delay slot kept
        add(0, 0, 32'h0,   1, 32'h104, 0, 32'h00);
`else
        add(0, 0, 32'h0,   1, 32'h100, 0, 32'h00);
        add(0, 0, 32'h0,   1, 32'h104, 0, 32'h00);
`endif
        add(0, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,   1, 32'h10C, 1, 32'h104);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].stall;
            branch_flag   = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(negedge clk);
            check($sformatf("vec%0d_ce", i),    rom_ce,   vecs[i].exp_ce);
            check($sformatf("vec%0d_addr", i),  rom_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), id_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_pc", i),    id_pc,    vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i),  id_inst,
                  vecs[i].exp_valid ? (vecs[i].exp_pc >> 2) : 32'h0);
            step();
        end
        stall       = 1'b0;
        branch_flag = 1'b0;

        // ---------------- stall from reset: exactly DEPTH issues, ordered drain -----
        do_reset();
        stall = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rom_ce) n++;
            step();
        end
        check("stall_issue_count", n, 32'd4);
        check("stall_head_pc", id_pc, 32'h0);
        stall = 1'b0;
        next_pop("drain0", 32'h0);
        next_pop("drain1", 32'h4);
        next_pop("drain2", 32'h8);
        next_pop("drain3", 32'hC);

        // ---------------- async reset mid-run with three queued + one inflight -------
        do_reset();
        stall = 1'b1;
        repeat (4) step();
        check("pre_rst_valid", id_valid, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", id_valid, 32'h0);
        check("async_rst_pc",    id_pc,    32'h0);
        check("async_rst_inst",  id_inst,  32'h0);
        check("async_rst_ce",    rom_ce,   32'h0);
        check("async_rst_addr",  rom_addr, 32'h0);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("restart_ce",   rom_ce,   32'h1);
        check("restart_addr", rom_addr, 32'h0);
        step();
        next_pop("restart_pop0", 32'h0);
        next_pop("restart_pop1", 32'h4);

        // ---------------- PC wrap at the top of the address space --------------------
        do_reset();
        repeat (3) step();
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        @(negedge clk);
        check("wrap_branch_head", id_pc, 32'h4);
        step();
        branch_flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rom_ce) issued.push_back(rom_addr);
            if (id_valid) ids.push_back(id_pc);
            step();
        end
        exp_wrap[0] = 32'hFFFF_FFF8;
        exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000;
`ifdef TORU_DELAY_SLOT_EN
        off = 1;
`else
        off = 0;
`endif
        check("wrap_issue_count_ok", (issued.size() >= 3) ? 32'h1 : 32'h0, 32'h1);
        check("wrap_id_count_ok", (ids.size() >= 3 + off) ? 32'h1 : 32'h0, 32'h1);
        if (issued.size() >= 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("wrap_issue%0d", k), issued[k], exp_wrap[k]);
        end
        if (ids.size() >= 3 + off) begin
            if (off == 1) check("wrap_ds_id", ids[0], 32'h8);
            for (int k = 0; k < 3; k++)
                check($sformatf("wrap_id%0d", k), ids[k + off], exp_wrap[k]);
        end

`ifdef TORU_DELAY_SLOT_EN
        // ---------------- delay slot kept from a full queue ---------------------------
        do_reset();
        stall = 1'b1;
        repeat (6) step();
        stall         = 1'b0;
        branch_flag   = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        check("ds_full_branch_head", id_pc, 32'h0);
        check("ds_full_branch_ce", rom_ce, 32'h0);
        step();
        branch_flag = 1'b0;
        next_pop("ds_full_slot", 32'h4);
        next_pop("ds_full_target", 32'h100);

        // ---------------- delay slot not yet fetched: DS_FETCH path --------------------
        do_reset();
        repeat (2) step();
        branch_flag   = 1'b1;
        branch_target = 32'h20;
        @(negedge clk);
        check("ds1_head", id_pc, 32'h0);
        step();
        branch_target = 32'h200;
        @(negedge clk);
        check("ds2_head", id_pc, 32'h4);
        check("ds2_ce", rom_ce, 32'h0);
        step();
        branch_flag = 1'b0;
        @(negedge clk);
        check("dsf_ce",    rom_ce,   32'h1);
        check("dsf_addr",  rom_addr, 32'h20);
        check("dsf_valid", id_valid, 32'h0);
        step();
        @(negedge clk);
        check("dsf_tgt_ce",   rom_ce,   32'h1);
        check("dsf_tgt_addr", rom_addr, 32'h200);
        step();
        next_pop("dsf_slot", 32'h20);
        next_pop("dsf_target", 32'h200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
